axi_pmu_regif: RTL and testbench
================================

Name: axi_pmu_regif

Overview:
- Parametrised AXI4-Lite slave bridging the Lagarto PMU register bank (counters and config registers) to the OpenPiton AXI-Lite peripheral bus.
- Successor to the fixed 64-bit PMU AXI handler. Adds:
  - parametrised data width, counter count, base address and index width;
  - address decode with SLVERR on out-of-range, misaligned or partial-strobe accesses;
  - per-request timeout;
  - independent read and write FSMs driving the bank's separate read and write ports.

Parameters:
- C_S_AXI_DATA_WIDTH, 64, AXI data width and counter width; 32 or 64 only.
- C_S_AXI_ADDR_WIDTH, 64, AXI address width.
- N_COUNTERS, 32, number of addressable registers, 1..2**CNT_ADDR_WIDTH.
- CNT_ADDR_WIDTH, 8, width of the register-bank index.
- BASE_ADDR, 64'hFFF5100000, byte address of register 0.
- TIMEOUT_CYCLES, 256, maximum wait for bank valid before error; minimum 2.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESET  in  1  synchronous reset, active-high.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, S_AXI_WDATA/WSTRB/WVALID/WREADY, S_AXI_BRESP/BVALID/BREADY: standard AXI4-Lite write channels. AWPROT is ignored.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY, S_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite read channels. ARPROT is ignored.
- counter_read_enable  out  1  read request, held until valid or timeout.
- counter_read_valid  in  1  bank read data valid.
- counter_read_address  out  CNT_ADDR_WIDTH  register index.
- counter_read_data  in  C_S_AXI_DATA_WIDTH  bank read data.
- counter_write_enable  out  1  write request, held until valid or timeout.
- counter_write_valid  in  1  bank write done.
- counter_write_address  out  CNT_ADDR_WIDTH  register index.
- counter_write_data  out  C_S_AXI_DATA_WIDTH  write data.

Behaviour:
- Clocking and reset: single clock S_AXI_ACLK. Reset S_AXI_ARESET is synchronous, active-high.
- Outputs at reset: all outputs 0. Both FSMs go to IDLE. A reset mid-request drops the enables at the reset edge; no response is issued.
- Decode:
  - ADDR_LSB = log2(DATA_WIDTH/8).
  - idx = (addr - BASE_ADDR) >> ADDR_LSB.
  - The access is legal iff addr >= BASE_ADDR, addr[ADDR_LSB-1:0] == 0, and idx < N_COUNTERS.
  - Subtraction is done at full C_S_AXI_ADDR_WIDTH; idx is truncated to CNT_ADDR_WIDTH only after the range check.
- Write FSM states: W_IDLE, W_REQ, W_RESP.
  - W_IDLE: when AWVALID and WVALID are both high, AWREADY and WREADY pulse together for one cycle (registered, one cycle after both valids are seen). At that edge, addr, data and strb are latched.
  - If the access is legal and WSTRB is all ones, go to W_REQ. The next cycle has counter_write_enable=1 with address and data stable.
  - Otherwise go to W_RESP with BRESP=2'b10 (SLVERR). The bank is not touched.
  - W_REQ: when counter_write_valid is sampled high, drop the enable and go to W_RESP with BRESP=OKAY.
  - W_REQ timeout: when the timer reaches TIMEOUT_CYCLES-1, drop the enable and go to W_RESP with SLVERR.
  - W_RESP: BVALID is held until BREADY, then return to W_IDLE. No new AW/W is accepted before then.
- Read FSM states: R_IDLE, R_REQ, R_RESP. Structure mirrors the write FSM.
  - R_IDLE: ARREADY pulses for one cycle after ARVALID is seen.
  - Legal access: go to R_REQ.
  - Illegal access: go to R_RESP with RRESP=SLVERR and RDATA=0.
  - Valid received: RDATA is captured from counter_read_data in the same cycle and RRESP=OKAY.
  - Timeout: RDATA=0, RRESP=SLVERR.
  - R_RESP: RVALID and RDATA are held stable until RREADY. RDATA returns to 0 after the handshake.
- Timer: one per FSM. Cleared on entry to REQ and saturating. A valid arriving in the same cycle as timeout counts as success.
- Concurrency: read and write FSMs are fully independent. Simultaneous read and write to the same index both proceed; ordering is the bank's responsibility.
- Latency, legal write: both valids seen at edge 0 → ready at edge 1 → enable high from cycle 2 → valid sampled at edge k → BVALID from cycle k+1. Reads have the same latency.

Optional Feature:
- Macro: AXI_PMU_REGIF_CDC_SYNC_EN.
- Defined:
  - counter_read_valid and counter_write_valid pass through 2-flop synchronizers, adding 2 cycles of latency.
  - After a completion or timeout, the FSM stays in RESP until the synchronized valid is also low, giving a 4-phase handshake. It then returns to IDLE.
  - The timeout still applies in REQ.
- Undefined: valids are sampled directly and no low-wait is performed.

Decomposition:
- Package axi_pmu_regif_pkg contains:
  - RESP_OKAY/RESP_SLVERR constants;
  - w_state_t and r_state_t enums;
  - addr_lsb(width) function.
- One sub-module, pmu_valid_sync, holds the 2-flop synchronizer. It is instantiated only under AXI_PMU_REGIF_CDC_SYNC_EN.

Test Plan:
- Legal write: AWADDR=BASE+0x18, WDATA=0xDEAD_BEEF_0000_0001, WSTRB=0xFF, bank valid after 3 cycles → write_address=3, write_data matches, BRESP=00, one BVALID.
- Legal read: ARADDR=BASE+0x08, bank returns 0x1234 → read_address=1, RDATA=0x1234, RRESP=00, RDATA stable with RREADY held low for 5 cycles.
- Decode errors:
  - ARADDR=BASE+N_COUNTERS*8 → RRESP=10, RDATA=0, read_enable never asserted.
  - AWADDR=BASE+0x04 → BRESP=10.
  - AWADDR=BASE-8 → BRESP=10.
  - WSTRB=0x0F → BRESP=10.
- Timeout: bank valid never asserted, TIMEOUT_CYCLES=16 → enable high exactly 16 cycles, then SLVERR.
- Concurrency and reset: simultaneous read of idx 2 and write of idx 5 both complete OKAY. A reset asserted during W_REQ → enable=0 next cycle, no BVALID, and the next write works.

Source files
------------

// File: rtl/axi_pmu_regif_pkg.sv
// Shared types and constants for the PMU AXI4-Lite register interface.
// Optional CDC synchronisation is selected with AXI_PMU_REGIF_CDC_SYNC_EN.
`timescale 1ns/1ps
package axi_pmu_regif_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_REQ,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_RESP
    } r_state_t;

    // Byte-offset bits covered by one data word.
    function automatic int addr_lsb(input int width);
        return $clog2(width / 8);
    endfunction

endpackage

// File: rtl/axi_pmu_regif_if.sv
// AXI4-Lite bus bundle between the OpenPiton peripheral master and the PMU slave.
`timescale 1ns/1ps
interface axi_pmu_regif_if #(
    parameter int DW = 64,
    parameter int AW = 64
);
    logic [AW-1:0]   AWADDR;
    logic [2:0]      AWPROT;
    logic            AWVALID;
    logic            AWREADY;
    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WVALID;
    logic            WREADY;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [AW-1:0]   ARADDR;
    logic [2:0]      ARPROT;
    logic            ARVALID;
    logic            ARREADY;
    logic [DW-1:0]   RDATA;
    logic [1:0]      RRESP;
    logic            RVALID;
    logic            RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axi_pmu_regif_valid_sync.sv
// Two-flop synchroniser for the bank valid strobes.
// Only compiled when AXI_PMU_REGIF_CDC_SYNC_EN is defined.
`timescale 1ns/1ps
`ifdef AXI_PMU_REGIF_CDC_SYNC_EN
module pmu_valid_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            o_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end
endmodule
`endif

// File: rtl/axi_pmu_regif.sv
// AXI4-Lite slave to Lagarto PMU register bank with decode errors and per-request timeout.
// Define AXI_PMU_REGIF_CDC_SYNC_EN to synchronise bank valids and wait for them to fall.
`timescale 1ns/1ps
module axi_pmu_regif
    import axi_pmu_regif_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 64,
    parameter int          C_S_AXI_ADDR_WIDTH = 64,
    parameter int          N_COUNTERS         = 32,
    parameter int          CNT_ADDR_WIDTH     = 8,
    parameter logic [63:0] BASE_ADDR          = 64'hFFF5100000,
    parameter int          TIMEOUT_CYCLES     = 256
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    axi_pmu_regif_if.slave                s_axi,
    output logic                          counter_read_enable,
    input  logic                          counter_read_valid,
    output logic [CNT_ADDR_WIDTH-1:0]     counter_read_address,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] counter_read_data,
    output logic                          counter_write_enable,
    input  logic                          counter_write_valid,
    output logic [CNT_ADDR_WIDTH-1:0]     counter_write_address,
    output logic [C_S_AXI_DATA_WIDTH-1:0] counter_write_data
);
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int CW       = CNT_ADDR_WIDTH;
    localparam int ADDR_LSB = addr_lsb(C_S_AXI_DATA_WIDTH);
    localparam int TW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [AW-1:0] BASE     = AW'(BASE_ADDR);
    localparam logic [TW-1:0] TIMER_TC = TW'(TIMEOUT_CYCLES - 1);

    // Range check is done on the full-width offset before truncating to the index.
    function automatic logic is_legal(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = a - BASE;
        return (a >= BASE) && (a[ADDR_LSB-1:0] == '0) && ((off >> ADDR_LSB) < AW'(N_COUNTERS));
    endfunction

    function automatic logic [CW-1:0] to_idx(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = a - BASE;
        return CW'(off >> ADDR_LSB);
    endfunction

    w_state_t      r_wstate;
    r_state_t      r_rstate;
    logic [TW-1:0] r_wtimer;
    logic [TW-1:0] r_rtimer;
    logic          w_wr_valid;
    logic          w_rd_valid;
    logic          w_unused_prot;

    assign w_unused_prot = ^{s_axi.AWPROT, s_axi.ARPROT};

`ifdef AXI_PMU_REGIF_CDC_SYNC_EN
    pmu_valid_sync u_wr_sync (
        .i_clk (S_AXI_ACLK),
        .i_rst (S_AXI_ARESET),
        .i_d   (counter_write_valid),
        .o_q   (w_wr_valid)
    );

    pmu_valid_sync u_rd_sync (
        .i_clk (S_AXI_ACLK),
        .i_rst (S_AXI_ARESET),
        .i_d   (counter_read_valid),
        .o_q   (w_rd_valid)
    );
`else
    assign w_wr_valid = counter_write_valid;
    assign w_rd_valid = counter_read_valid;
`endif

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_wstate              <= W_IDLE;
            r_wtimer              <= '0;
            s_axi.AWREADY         <= 1'b0;
            s_axi.WREADY          <= 1'b0;
            s_axi.BVALID          <= 1'b0;
            s_axi.BRESP           <= RESP_OKAY;
            counter_write_enable  <= 1'b0;
            counter_write_address <= '0;
            counter_write_data    <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (s_axi.AWREADY) begin
                        // Handshake edge: the master still holds address, data and strobe.
                        s_axi.AWREADY <= 1'b0;
                        s_axi.WREADY  <= 1'b0;
                        if (is_legal(s_axi.AWADDR) && (&s_axi.WSTRB)) begin
                            counter_write_address <= to_idx(s_axi.AWADDR);
                            counter_write_data    <= s_axi.WDATA;
                            counter_write_enable  <= 1'b1;
                            r_wtimer              <= '0;
                            r_wstate              <= W_REQ;
                        end else begin
                            s_axi.BVALID <= 1'b1;
                            s_axi.BRESP  <= RESP_SLVERR;
                            r_wstate     <= W_RESP;
                        end
                    end else if (s_axi.AWVALID && s_axi.WVALID) begin
                        s_axi.AWREADY <= 1'b1;
                        s_axi.WREADY  <= 1'b1;
                    end
                end
                W_REQ: begin
                    if (w_wr_valid) begin
                        counter_write_enable <= 1'b0;
                        s_axi.BVALID         <= 1'b1;
                        s_axi.BRESP          <= RESP_OKAY;
                        r_wstate             <= W_RESP;
                    end else if (r_wtimer == TIMER_TC) begin
                        counter_write_enable <= 1'b0;
                        s_axi.BVALID         <= 1'b1;
                        s_axi.BRESP          <= RESP_SLVERR;
                        r_wstate             <= W_RESP;
                    end else begin
                        r_wtimer <= r_wtimer + 1'b1;
                    end
                end
                W_RESP: begin
`ifdef AXI_PMU_REGIF_CDC_SYNC_EN
                    if (s_axi.BVALID && s_axi.BREADY) begin
                        s_axi.BVALID <= 1'b0;
                        if (!w_wr_valid) r_wstate <= W_IDLE;
                    end else if (!s_axi.BVALID && !w_wr_valid) begin
                        r_wstate <= W_IDLE;
                    end
`else
                    if (s_axi.BREADY) begin
                        s_axi.BVALID <= 1'b0;
                        r_wstate     <= W_IDLE;
                    end
`endif
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_rstate             <= R_IDLE;
            r_rtimer             <= '0;
            s_axi.ARREADY        <= 1'b0;
            s_axi.RVALID         <= 1'b0;
            s_axi.RRESP          <= RESP_OKAY;
            s_axi.RDATA          <= '0;
            counter_read_enable  <= 1'b0;
            counter_read_address <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (s_axi.ARREADY) begin
                        s_axi.ARREADY <= 1'b0;
                        if (is_legal(s_axi.ARADDR)) begin
                            counter_read_address <= to_idx(s_axi.ARADDR);
                            counter_read_enable  <= 1'b1;
                            r_rtimer             <= '0;
                            r_rstate             <= R_REQ;
                        end else begin
                            s_axi.RVALID <= 1'b1;
                            s_axi.RRESP  <= RESP_SLVERR;
                            s_axi.RDATA  <= '0;
                            r_rstate     <= R_RESP;
                        end
                    end else if (s_axi.ARVALID) begin
                        s_axi.ARREADY <= 1'b1;
                    end
                end
                R_REQ: begin
                    if (w_rd_valid) begin
                        counter_read_enable <= 1'b0;
                        s_axi.RVALID        <= 1'b1;
                        s_axi.RRESP         <= RESP_OKAY;
                        s_axi.RDATA         <= counter_read_data;
                        r_rstate            <= R_RESP;
                    end else if (r_rtimer == TIMER_TC) begin
                        counter_read_enable <= 1'b0;
                        s_axi.RVALID        <= 1'b1;
                        s_axi.RRESP         <= RESP_SLVERR;
                        s_axi.RDATA         <= '0;
                        r_rstate            <= R_RESP;
                    end else begin
                        r_rtimer <= r_rtimer + 1'b1;
                    end
                end
                R_RESP: begin
`ifdef AXI_PMU_REGIF_CDC_SYNC_EN
                    if (s_axi.RVALID && s_axi.RREADY) begin
                        s_axi.RVALID <= 1'b0;
                        s_axi.RDATA  <= '0;
                        if (!w_rd_valid) r_rstate <= R_IDLE;
                    end else if (!s_axi.RVALID && !w_rd_valid) begin
                        r_rstate <= R_IDLE;
                    end
`else
                    if (s_axi.RREADY) begin
                        s_axi.RVALID <= 1'b0;
                        s_axi.RDATA  <= '0;
                        r_rstate     <= R_IDLE;
                    end
`endif
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_pmu_regif.sv
// Self-checking bench for axi_pmu_regif: vector table with response scoreboard plus
// hand-written timeout, RREADY back-pressure, concurrency and mid-request reset sequences.
`timescale 1ns/1ps
module tb_axi_pmu_regif;
    import axi_pmu_regif_pkg::*;

    localparam logic [63:0] BASE = 64'hFFF5100000;
    localparam int NV = 10;

    typedef struct {
        bit          is_wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  strb;
        int          delay;
        logic [1:0]  exp_resp;
        logic [63:0] exp_rdata;
        bit          exp_touch;
        logic [7:0]  exp_idx;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        cre, crv, cwe, cwv;
    logic [7:0]  cra, cwa;
    logic [63:0] crd, cwd;

    axi_pmu_regif_if #(.DW(64), .AW(64)) bus ();

    axi_pmu_regif #(
        .C_S_AXI_DATA_WIDTH (64),
        .C_S_AXI_ADDR_WIDTH (64),
        .N_COUNTERS         (32),
        .CNT_ADDR_WIDTH     (8),
        .BASE_ADDR          (BASE),
        .TIMEOUT_CYCLES     (16)
    ) dut (
        .S_AXI_ACLK            (clk),
        .S_AXI_ARESET          (rst),
        .s_axi                 (bus),
        .counter_read_enable   (cre),
        .counter_read_valid    (crv),
        .counter_read_address  (cra),
        .counter_read_data     (crd),
        .counter_write_enable  (cwe),
        .counter_write_valid   (cwv),
        .counter_write_address (cwa),
        .counter_write_data    (cwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Register-bank model: answers each request after a programmable number of cycles.
    logic [63:0] mem [0:255];
    int          w_delay = 0, r_delay = 0;
    int          wcnt = 0, rcnt = 0;
    int          wen_cycles = 0, ren_cycles = 0;
    logic [7:0]  w_cap_addr = '0, r_cap_addr = '0;
    logic [63:0] w_cap_data = '0;

    initial begin
        cwv = 1'b0;
        crv = 1'b0;
        crd = '0;
    end

    always @(negedge clk) begin
        if (cwe) begin
            wen_cycles = wen_cycles + 1;
            if (wcnt == w_delay) begin
                cwv        = 1'b1;
                mem[cwa]   = cwd;
                w_cap_addr = cwa;
                w_cap_data = cwd;
                wcnt       = 0;
            end else begin
                cwv  = 1'b0;
                wcnt = wcnt + 1;
            end
        end else begin
            cwv  = 1'b0;
            wcnt = 0;
        end
    end

    always @(negedge clk) begin
        if (cre) begin
            ren_cycles = ren_cycles + 1;
            if (rcnt == r_delay) begin
                crv        = 1'b1;
                crd        = mem[cra];
                r_cap_addr = cra;
                rcnt       = 0;
            end else begin
                crv  = 1'b0;
                crd  = '0;
                rcnt = rcnt + 1;
            end
        end else begin
            crv  = 1'b0;
            crd  = '0;
            rcnt = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                            output logic [1:0] resp, output bit got);
        int n;
        got  = 0;
        resp = 2'b11;
        @(posedge clk); #1;
        bus.AWADDR  = a;
        bus.WDATA   = d;
        bus.WSTRB   = s;
        bus.AWVALID = 1'b1;
        bus.WVALID  = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (bus.AWREADY && bus.WREADY) break;
            n++;
        end
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        bus.BREADY  = 1'b1;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (bus.BVALID) begin
                resp = bus.BRESP;
                got  = 1;
                break;
            end
            n++;
        end
        @(posedge clk); #1;
        bus.BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [63:0] a, input int hold,
                           output logic [63:0] data, output logic [1:0] resp,
                           output bit got, output bit stable);
        int n;
        got    = 0;
        stable = 1;
        resp   = 2'b11;
        data   = 64'hX;
        @(posedge clk); #1;
        bus.ARADDR  = a;
        bus.ARVALID = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (bus.ARREADY) break;
            n++;
        end
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (bus.RVALID) begin
                resp = bus.RRESP;
                data = bus.RDATA;
                got  = 1;
                break;
            end
            n++;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus.RVALID || bus.RDATA !== data || bus.RRESP !== resp) stable = 0;
        end
        bus.RREADY = 1'b1;
        @(posedge clk); #1;
        bus.RREADY = 1'b0;
    endtask

    vec_t        vecs [NV];
    vec_t        exp_q [$];

    initial begin
        vec_t        v;
        vec_t        e;
        logic [1:0]  resp, resp2;
        logic [63:0] rdata;
        bit          got, got2, stable;
        int          n;

        bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
        bus.WDATA  = '0; bus.WSTRB  = '0; bus.WVALID  = 1'b0;
        bus.BREADY = 1'b0;
        bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        mem[1] = 64'h1234;
        mem[2] = 64'h55AA_0002;

        //          wr  addr          wdata                  strb   dly resp         rdata                  touch idx
        vecs[0] = '{1, BASE + 64'h18, 64'hDEAD_BEEF_0000_0001, 8'hFF, 3, RESP_OKAY,   64'h0,                 1, 8'd3};
        vecs[1] = '{0, BASE + 64'h08, 64'h0,                 8'h00, 1, RESP_OKAY,   64'h1234,              1, 8'd1};
        vecs[2] = '{0, BASE + 64'd256, 64'h0,                8'h00, 0, RESP_SLVERR, 64'h0,                 0, 8'd0};
        vecs[3] = '{1, BASE + 64'h04, 64'h1111,              8'hFF, 0, RESP_SLVERR, 64'h0,                 0, 8'd0};
        vecs[4] = '{1, BASE - 64'h08, 64'h2222,              8'hFF, 0, RESP_SLVERR, 64'h0,                 0, 8'd0};
        vecs[5] = '{1, BASE + 64'h28, 64'h3333,              8'h0F, 0, RESP_SLVERR, 64'h0,                 0, 8'd0};
        vecs[6] = '{1, BASE + 64'hF8, 64'hCAFE_F00D_1234_5678, 8'hFF, 0, RESP_OKAY,   64'h0,                 1, 8'd31};
        vecs[7] = '{0, BASE + 64'hF8, 64'h0,                 8'h00, 0, RESP_OKAY,   64'hCAFE_F00D_1234_5678, 1, 8'd31};
        vecs[8] = '{0, BASE + 64'h04, 64'h0,                 8'h00, 0, RESP_SLVERR, 64'h0,                 0, 8'd0};
        vecs[9] = '{0, BASE + 64'h18, 64'h0,                 8'h00, 2, RESP_OKAY,   64'hDEAD_BEEF_0000_0001, 1, 8'd3};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {56'h0, bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID, cre, cwe, 1'b0}, 64'h0);
        chk("reset_resp_idx", {44'h0, bus.BRESP, bus.RRESP, cra, cwa}, 64'h0);
        chk("reset_rdata", bus.RDATA, 64'h0);
        chk("reset_wdata", cwd, 64'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            exp_q.push_back(v);
            if (v.is_wr) begin
                w_delay    = v.delay;
                wen_cycles = 0;
                do_write(v.addr, v.wdata, v.strb, resp, got);
                e = exp_q.pop_front();
                chk($sformatf("v%0d_bresp", i), 64'(resp), 64'(e.exp_resp));
                chk($sformatf("v%0d_wr_touch", i), 64'(wen_cycles != 0), 64'(e.exp_touch));
                if (e.exp_touch) begin
                    chk($sformatf("v%0d_wr_idx", i), 64'(w_cap_addr), 64'(e.exp_idx));
                    chk($sformatf("v%0d_wr_data", i), w_cap_data, e.wdata);
                end
                @(negedge clk);
                chk($sformatf("v%0d_bvalid_once", i), 64'(bus.BVALID), 64'h0);
            end else begin
                r_delay    = v.delay;
                ren_cycles = 0;
                do_read(v.addr, 0, rdata, resp, got, stable);
                e = exp_q.pop_front();
                chk($sformatf("v%0d_rresp", i), 64'(resp), 64'(e.exp_resp));
                chk($sformatf("v%0d_rdata", i), rdata, e.exp_rdata);
                chk($sformatf("v%0d_rd_touch", i), 64'(ren_cycles != 0), 64'(e.exp_touch));
                if (e.exp_touch) chk($sformatf("v%0d_rd_idx", i), 64'(r_cap_addr), 64'(e.exp_idx));
            end
        end

        // RREADY held low for 5 cycles: response must not move, then clears.
        r_delay = 1;
        do_read(BASE + 64'h08, 5, rdata, resp, got, stable);
        chk("hold_rdata", rdata, 64'h1234);
        chk("hold_stable", 64'(stable), 64'h1);
        @(negedge clk);
        chk("hold_rdata_cleared", {bus.RDATA[62:0], bus.RVALID}, 64'h0);

        // Bank never answers: enable stays high for exactly the timeout window.
        w_delay = 1000;
        wen_cycles = 0;
        do_write(BASE + 64'h20, 64'h77, 8'hFF, resp, got);
        chk("wr_timeout_resp", 64'(resp), 64'(RESP_SLVERR));
        chk("wr_timeout_cycles", 64'(wen_cycles), 64'd16);
        r_delay = 1000;
        ren_cycles = 0;
        do_read(BASE + 64'h20, 0, rdata, resp, got, stable);
        chk("rd_timeout_resp", 64'(resp), 64'(RESP_SLVERR));
        chk("rd_timeout_rdata", rdata, 64'h0);
        chk("rd_timeout_cycles", 64'(ren_cycles), 64'd16);

        // Independent channels in flight together.
        w_delay = 2;
        r_delay = 1;
        fork
            do_write(BASE + 64'h28, 64'h5555_0005, 8'hFF, resp2, got2);
            do_read(BASE + 64'h10, 0, rdata, resp, got, stable);
        join
        chk("conc_bresp", 64'(resp2), 64'(RESP_OKAY));
        chk("conc_widx", 64'(w_cap_addr), 64'd5);
        chk("conc_rresp", 64'(resp), 64'(RESP_OKAY));
        chk("conc_rdata", rdata, 64'h55AA_0002);

        // Reset while the write request is outstanding.
        w_delay = 1000;
        @(posedge clk); #1;
        bus.AWADDR = BASE + 64'h30; bus.WDATA = 64'h99; bus.WSTRB = 8'hFF;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        n = 0;
        while (!(bus.AWREADY) && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        n = 0;
        while (!cwe && n < 20) begin @(negedge clk); n++; end
        chk("rst_req_started", 64'(cwe), 64'h1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_enable_drop", 64'(cwe), 64'h0);
        n = 0;
        bus.BREADY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.BVALID) n++;
        end
        bus.BREADY = 1'b0;
        chk("rst_no_bvalid", 64'(n), 64'h0);
        w_delay = 1;
        do_write(BASE + 64'h38, 64'hABCD_0007, 8'hFF, resp, got);
        chk("post_rst_bresp", 64'(resp), 64'(RESP_OKAY));
        chk("post_rst_idx", 64'(w_cap_addr), 64'd7);
        chk("post_rst_data", w_cap_data, 64'hABCD_0007);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
